// File: rtl/dsp48a1_slice.sv
// Single DSP48A1-style slice: 18-bit pre-adder, 18x18 multiplier, 48-bit post-adder/accumulator.
// Optional elaboration-time parameter checking is enabled by defining DSP_PARAM_CHECK_EN.

module dsp48a1_stage #(
    parameter int W  = 1,
    parameter bit EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] r;

    always_ff @(posedge clk) begin
        if (rst)
            r <= '0;
        else if (ce)
            r <= d;
    end

    // Unregistered stages bypass the flop; synthesis drops the unused register.
    assign q = EN ? r : d;
endmodule

module dsp48a1_slice #(
    parameter int    A0REG       = 0,
    parameter int    A1REG       = 1,
    parameter int    B0REG       = 0,
    parameter int    B1REG       = 1,
    parameter int    CREG        = 1,
    parameter int    DREG        = 1,
    parameter int    MREG        = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter int    OPMODEREG   = 1,
    parameter string CARRYINSEL  = "OPMODE5",
    parameter string B_INPUT     = "DIRECT",
    parameter string RSTTYPE     = "SYNC"
) (
    input  logic        clk,
    input  logic        RSTA,
    input  logic        RSTB,
    input  logic        RSTC,
    input  logic        RSTD,
    input  logic        RSTM,
    input  logic        RSTP,
    input  logic        RSTCARRYIN,
    input  logic        RSTOPMODE,
    input  logic        CEA,
    input  logic        CEB,
    input  logic        CEC,
    input  logic        CED,
    input  logic        CEM,
    input  logic        CEP,
    input  logic        CECARRYIN,
    input  logic        CEOPMODE,
    input  logic [17:0] A,
    input  logic [17:0] B,
    input  logic [17:0] BCIN,
    input  logic [17:0] D,
    input  logic [47:0] C,
    input  logic [47:0] PCIN,
    input  logic        CARRYIN,
    input  logic [7:0]  OPMODE,
    output logic [47:0] P,
    output logic [47:0] PCOUT,
    output logic [35:0] M,
    output logic [17:0] BCOUT,
    output logic        CARRYOUT,
    output logic        CARRYOUTF
);

`ifdef DSP_PARAM_CHECK_EN
    if (A0REG > 1 || A0REG < 0 || A1REG > 1 || A1REG < 0 || B0REG > 1 || B0REG < 0 ||
        B1REG > 1 || B1REG < 0 || CREG > 1 || CREG < 0 || DREG > 1 || DREG < 0 ||
        MREG > 1 || MREG < 0 || PREG > 1 || PREG < 0 || CARRYINREG > 1 || CARRYINREG < 0 ||
        CARRYOUTREG > 1 || CARRYOUTREG < 0 || OPMODEREG > 1 || OPMODEREG < 0) begin : g_bad_reg
        $fatal(1, "dsp48a1_slice: every *REG parameter must be 0 or 1");
    end
    if (CARRYINSEL != "OPMODE5" && CARRYINSEL != "CARRYIN") begin : g_bad_cysel
        $fatal(1, "dsp48a1_slice: CARRYINSEL must be OPMODE5 or CARRYIN");
    end
    if (B_INPUT != "DIRECT" && B_INPUT != "CASCADE") begin : g_bad_binput
        $fatal(1, "dsp48a1_slice: B_INPUT must be DIRECT or CASCADE");
    end
    if (RSTTYPE != "SYNC") begin : g_bad_rsttype
        $fatal(1, "dsp48a1_slice: only RSTTYPE SYNC is supported");
    end
`endif

    // Anything other than the alternate string falls back to the default source.
    localparam bit CY_FROM_PORT = (CARRYINSEL == "CARRYIN");
    localparam bit B_CASCADE    = (B_INPUT == "CASCADE");

    logic [17:0] a0_q, a1_q, b_src, b0_q, b1_d, b1_q, d_s, preadd;
    logic [7:0]  op;
    logic [35:0] mult, m_q;
    logic [47:0] c_q, x_mux, z_mux, p_q;
    logic        cyi_d, cyi_q, cyo_q;
    logic [48:0] post;

    dsp48a1_stage #(.W(8), .EN(OPMODEREG != 0)) u_opmode (
        .clk(clk), .rst(RSTOPMODE), .ce(CEOPMODE), .d(OPMODE), .q(op));

    dsp48a1_stage #(.W(18), .EN(A0REG != 0)) u_a0 (
        .clk(clk), .rst(RSTA), .ce(CEA), .d(A), .q(a0_q));
    dsp48a1_stage #(.W(18), .EN(A1REG != 0)) u_a1 (
        .clk(clk), .rst(RSTA), .ce(CEA), .d(a0_q), .q(a1_q));

    assign b_src = B_CASCADE ? BCIN : B;
    dsp48a1_stage #(.W(18), .EN(B0REG != 0)) u_b0 (
        .clk(clk), .rst(RSTB), .ce(CEB), .d(b_src), .q(b0_q));

    dsp48a1_stage #(.W(18), .EN(DREG != 0)) u_d (
        .clk(clk), .rst(RSTD), .ce(CED), .d(D), .q(d_s));

    assign preadd = op[6] ? (d_s - b0_q) : (d_s + b0_q);
    assign b1_d   = op[4] ? preadd : b0_q;

    dsp48a1_stage #(.W(18), .EN(B1REG != 0)) u_b1 (
        .clk(clk), .rst(RSTB), .ce(CEB), .d(b1_d), .q(b1_q));

    assign mult = {18'd0, a1_q} * {18'd0, b1_q};
    dsp48a1_stage #(.W(36), .EN(MREG != 0)) u_m (
        .clk(clk), .rst(RSTM), .ce(CEM), .d(mult), .q(m_q));

    dsp48a1_stage #(.W(48), .EN(CREG != 0)) u_c (
        .clk(clk), .rst(RSTC), .ce(CEC), .d(C), .q(c_q));

    always_comb begin
        x_mux = '0;
        case (op[1:0])
            2'd1:    x_mux = {12'd0, m_q};
            2'd2:    x_mux = p_q;
            2'd3:    x_mux = {d_s[11:0], a1_q, b1_q};
            default: x_mux = '0;
        endcase
    end

    always_comb begin
        z_mux = '0;
        case (op[3:2])
            2'd1:    z_mux = PCIN;
            2'd2:    z_mux = p_q;
            2'd3:    z_mux = c_q;
            default: z_mux = '0;
        endcase
    end

    assign cyi_d = CY_FROM_PORT ? CARRYIN : op[5];
    dsp48a1_stage #(.W(1), .EN(CARRYINREG != 0)) u_cyi (
        .clk(clk), .rst(RSTCARRYIN), .ce(CECARRYIN), .d(cyi_d), .q(cyi_q));

    // Bit 48 of the 49-bit result is the carry (or borrow, when subtracting).
    always_comb begin
        post = '0;
        if (op[7])
            post = {1'b0, z_mux} - ({1'b0, x_mux} + {48'd0, cyi_q});
        else
            post = {1'b0, z_mux} + {1'b0, x_mux} + {48'd0, cyi_q};
    end

    dsp48a1_stage #(.W(48), .EN(PREG != 0)) u_p (
        .clk(clk), .rst(RSTP), .ce(CEP), .d(post[47:0]), .q(p_q));
    dsp48a1_stage #(.W(1), .EN(CARRYOUTREG != 0)) u_cyo (
        .clk(clk), .rst(RSTCARRYIN), .ce(CECARRYIN), .d(post[48]), .q(cyo_q));

    assign P         = p_q;
    assign PCOUT     = p_q;
    assign M         = m_q;
    assign BCOUT     = b1_q;
    assign CARRYOUT  = cyo_q;
    assign CARRYOUTF = cyo_q;

endmodule

// File: tb/tb_dsp48a1_slice.sv
// Directed bench for dsp48a1_slice: a default-parameter slice and a cascade/CARRYIN-configured slice.

module tb_dsp48a1_slice;
    logic        clk = 1'b0;
    logic        RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE;
    logic        CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE;
    logic [17:0] A, B, BCIN, D;
    logic [47:0] C, PCIN;
    logic        CARRYIN;
    logic [7:0]  OPMODE;

    logic [47:0] P, PCOUT, P2, PCOUT2;
    logic [35:0] M, M2;
    logic [17:0] BCOUT, BCOUT2;
    logic        CARRYOUT, CARRYOUTF, CARRYOUT2, CARRYOUTF2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dsp48a1_slice u_dut (
        .clk(clk), .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD), .RSTM(RSTM),
        .RSTP(RSTP), .RSTCARRYIN(RSTCARRYIN), .RSTOPMODE(RSTOPMODE),
        .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED), .CEM(CEM), .CEP(CEP),
        .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
        .A(A), .B(B), .BCIN(BCIN), .D(D), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN),
        .OPMODE(OPMODE), .P(P), .PCOUT(PCOUT), .M(M), .BCOUT(BCOUT),
        .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF));

    dsp48a1_slice #(.CARRYINSEL("CARRYIN"), .B_INPUT("CASCADE")) u_dut_casc (
        .clk(clk), .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD), .RSTM(RSTM),
        .RSTP(RSTP), .RSTCARRYIN(RSTCARRYIN), .RSTOPMODE(RSTOPMODE),
        .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED), .CEM(CEM), .CEP(CEP),
        .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
        .A(A), .B(B), .BCIN(BCIN), .D(D), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN),
        .OPMODE(OPMODE), .P(P2), .PCOUT(PCOUT2), .M(M2), .BCOUT(BCOUT2),
        .CARRYOUT(CARRYOUT2), .CARRYOUTF(CARRYOUTF2));

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%012h expected 0x%012h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_rst(input logic v);
        RSTA = v; RSTB = v; RSTC = v; RSTD = v; RSTM = v; RSTP = v;
        RSTCARRYIN = v; RSTOPMODE = v;
    endtask

    initial begin
        CEA = 1; CEB = 1; CEC = 1; CED = 1; CEM = 1; CEP = 1; CECARRYIN = 1; CEOPMODE = 1;
        A = 0; B = 0; BCIN = 0; D = 0; C = 0; PCIN = 0; CARRYIN = 0; OPMODE = 0;
        set_rst(1'b1);
        tick(2);
        chk("rst_p", P, 48'd0);
        chk("rst_m", {12'd0, M}, 48'd0);
        chk("rst_bcout", {30'd0, BCOUT}, 48'd0);
        chk("rst_cyo", {47'd0, CARRYOUT}, 48'd0);
        set_rst(1'b0);

        // M*C path with pre-adder: 3*(7+4)+10
        A = 3; B = 4; D = 7; C = 10; OPMODE = 8'h1D;
        tick(6);
        chk("mac_p", P, 48'd43);
        chk("mac_pcout", PCOUT, 48'd43);
        chk("mac_m", {12'd0, M}, 48'd33);
        chk("mac_bcout", {30'd0, BCOUT}, 48'd11);
        chk("mac_cyo", {47'd0, CARRYOUT}, 48'd0);
        chk("mac_cyof", {47'd0, CARRYOUTF}, 48'd0);

        // P+P accumulate: opmode register delays the switch by one clock
        OPMODE = 8'h0A; A = 5; B = 6; D = 1; C = 99;
        tick(1);
        chk("acc_t1", P, 48'd43);
        tick(1);
        chk("acc_t2", P, 48'd86);
        tick(1);
        chk("acc_t3", P, 48'd172);
        tick(1);
        chk("acc_t4", P, 48'd344);

        // concatenation X input
        A = 1; B = 1; D = 1; C = 1; OPMODE = 8'h03;
        tick(6);
        chk("concat_p", P, 48'h0010_0004_0001);

        // P holds with CEP low
        CEP = 0; A = 7; B = 9; D = 3; OPMODE = 8'h1D;
        tick(4);
        chk("cep_hold", P, 48'h0010_0004_0001);
        CEP = 1;

        // 0 - 1 underflow
        A = 1; B = 1; D = 0; C = 0; OPMODE = 8'h81;
        tick(6);
        chk("uflow_p", P, 48'hFFFF_FFFF_FFFF);
        chk("uflow_cyo", {47'd0, CARRYOUT}, 48'd1);
        chk("uflow_cyof", {47'd0, CARRYOUTF}, 48'd1);

        // full reset with live inputs
        set_rst(1'b1);
        tick(1);
        chk("rstall_p", P, 48'd0);
        chk("rstall_m", {12'd0, M}, 48'd0);
        chk("rstall_bcout", {30'd0, BCOUT}, 48'd0);
        chk("rstall_cyo", {47'd0, CARRYOUT}, 48'd0);
        set_rst(1'b0);

        // P-only reset leaves M alone
        tick(6);
        chk("resettle_p", P, 48'hFFFF_FFFF_FFFF);
        RSTP = 1;
        tick(1);
        chk("rstp_p", P, 48'd0);
        chk("rstp_m", {12'd0, M}, 48'd1);
        RSTP = 0;

        // carry-in from OPMODE[5]: 100 + 2*3 + 1
        A = 2; B = 3; PCIN = 100; OPMODE = 8'h25;
        tick(6);
        chk("cyin_op5", P, 48'd107);

        // pre-subtract: 2*(10-3)+5
        A = 2; B = 3; D = 10; C = 5; OPMODE = 8'h5D;
        tick(6);
        chk("presub_p", P, 48'd19);

        // pre-subtract wrap: 0-1 = 0x3FFFF
        A = 1; B = 1; D = 0; C = 0;
        tick(6);
        chk("presub_wrap_bcout", {30'd0, BCOUT}, 48'h3FFFF);
        chk("presub_wrap_p", P, 48'h3FFFF);

        // cascade slice uses BCIN and CARRYIN; default slice uses B and OPMODE[5]
        A = 2; BCIN = 8; B = 9; PCIN = 20; CARRYIN = 1; D = 0; C = 0; OPMODE = 8'h85;
        tick(6);
        chk("casc_p", P2, 48'd3);
        chk("casc_bcout", {30'd0, BCOUT2}, 48'd8);
        chk("casc_cyo", {47'd0, CARRYOUT2}, 48'd0);
        chk("direct_p", P, 48'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
